// File: rtl/parameters.sv
// rtl/parameters.sv - shared sizes, LSU state encoding and RV32I load/store funct3 codes
package parameters;

  localparam int MSB        = 31;
  localparam int LSB        = 0;
  localparam int DMEM_BYTES = 128;

  typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  // Access size in bytes; the low two funct3 bits encode it for loads and stores alike.
  function automatic logic [2:0] acc_size(input logic [2:0] f3);
    case (f3[1:0])
      2'b00:   acc_size = 3'd1;
      2'b01:   acc_size = 3'd2;
      default: acc_size = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// rtl/lsu_align.sv - store byte-lane mask/data shifting and load shift with sign/zero extension
module lsu_align
  import parameters::*;
(
  input  logic [2:0]       funct3,
  input  logic [1:0]       offset,
  input  logic [MSB:LSB]   wdata,
  input  logic [MSB:LSB]   lo,
  input  logic [MSB:LSB]   hi,
  output logic [3:0]       we_lo,
  output logic [3:0]       we_hi,
  output logic [MSB:LSB]   wdata_lo,
  output logic [MSB:LSB]   wdata_hi,
  output logic [MSB:LSB]   rdata
);

  logic [3:0]  mask;
  logic [7:0]  mask_sh;
  logic [63:0] wsh;
  logic [31:0] rsh;
  logic [4:0]  sh_bits;

  always_comb begin
    sh_bits = {offset, 3'b000};
    case (funct3[1:0])
      2'b00:   mask = 4'b0001;
      2'b01:   mask = 4'b0011;
      default: mask = 4'b1111;
    endcase
    // The upper half of each 8/64-bit shift is exactly what spills into the next word.
    mask_sh  = {4'b0000, mask} << offset;
    wsh      = {32'h0, wdata} << sh_bits;
    we_lo    = mask_sh[3:0];
    we_hi    = mask_sh[7:4];
    wdata_lo = wsh[31:0];
    wdata_hi = wsh[63:32];

    rsh = 32'({hi, lo} >> sh_bits);
    case (funct3)
      F3_B:    rdata = {{24{rsh[7]}}, rsh[7:0]};
      F3_BU:   rdata = {24'h0, rsh[7:0]};
      F3_H:    rdata = {{16{rsh[15]}}, rsh[15:0]};
      F3_HU:   rdata = {16'h0, rsh[15:0]};
      default: rdata = rsh;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// rtl/lsu_ctrl.sv - load/store unit: request checking, split dmem accesses and load response
module lsu_ctrl
  import parameters::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [MSB:LSB]   req_addr,
  input  logic [MSB:LSB]   req_wdata,
  output logic             resp_valid,
  output logic [MSB:LSB]   resp_rdata,
  output logic             resp_fault,
  output logic [MSB:LSB]   daddr,
  output logic [MSB:LSB]   dwdata,
  output logic [3:0]       we,
  input  logic [MSB:LSB]   drdata
);

  lsu_state_t state, state_nx;

  logic           r_store;
  logic [2:0]     r_f3;
  logic [MSB:LSB] r_addr;
  logic [MSB:LSB] r_wdata;
  logic           r_cross;
  logic           r_fault;
  logic [MSB:LSB] buf_lo;
  logic [MSB:LSB] buf_hi;

  logic [2:0]     req_size;
  logic [32:0]    req_last;
  logic           req_legal;
  logic           req_cross;
  logic           req_fault;

  logic [MSB:LSB] lo_now;
  logic [MSB:LSB] hi_now;
  logic [3:0]     we_lo;
  logic [3:0]     we_hi;
  logic [MSB:LSB] wdata_lo;
  logic [MSB:LSB] wdata_hi;
  logic [MSB:LSB] rdata_ext;
  logic [MSB:LSB] word_addr;

  always_comb begin
    req_size = acc_size(req_funct3);
    // 33-bit end address so requests near the top of the address space fault instead of wrapping.
    req_last  = {1'b0, req_addr} + 33'(req_size) - 33'd1;
    req_cross = ({1'b0, req_addr[1:0]} + req_size) > 3'd4;
    if (req_store) begin
      req_legal = (req_funct3 < 3'b011);
    end else begin
      case (req_funct3)
        F3_B, F3_H, F3_W, F3_BU, F3_HU: req_legal = 1'b1;
        default:                        req_legal = 1'b0;
      endcase
    end
    req_fault = !req_legal || (req_last >= 33'(DMEM_BYTES));
  end

  // Feed the word being read this cycle straight through so the response can register on the same edge.
  assign lo_now    = (state == ACC0) ? drdata : buf_lo;
  assign hi_now    = (state == ACC1) ? drdata : buf_hi;
  assign word_addr = {r_addr[MSB:2], 2'b00};

  lsu_align u_align (
    .funct3   (r_f3),
    .offset   (r_addr[1:0]),
    .wdata    (r_wdata),
    .lo       (lo_now),
    .hi       (hi_now),
    .we_lo    (we_lo),
    .we_hi    (we_hi),
    .wdata_lo (wdata_lo),
    .wdata_hi (wdata_hi),
    .rdata    (rdata_ext)
  );

  always_comb begin
    state_nx   = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    daddr      = '0;
    dwdata     = '0;
    we         = 4'b0000;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nx = req_fault ? RESP : ACC0;
      end
      ACC0: begin
        daddr = word_addr;
        if (r_store) begin
          we     = we_lo;
          dwdata = wdata_lo;
        end
        state_nx = r_cross ? ACC1 : RESP;
      end
      ACC1: begin
        daddr = word_addr + 32'd4;
        if (r_store) begin
          we     = we_hi;
          dwdata = wdata_hi;
        end
        state_nx = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nx   = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      r_store    <= 1'b0;
      r_f3       <= 3'b000;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cross    <= 1'b0;
      r_fault    <= 1'b0;
      buf_lo     <= '0;
      buf_hi     <= '0;
      resp_rdata <= '0;
      resp_fault <= 1'b0;
    end else begin
      state <= state_nx;
      case (state)
        IDLE: begin
          if (req_valid) begin
            r_store <= req_store;
            r_f3    <= req_funct3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            r_cross <= req_cross;
            r_fault <= req_fault;
            buf_lo  <= '0;
            buf_hi  <= '0;
            if (req_fault) begin
              resp_rdata <= '0;
              resp_fault <= 1'b1;
            end
          end
        end
        ACC0: begin
          if (!r_store) buf_lo <= drdata;
          if (!r_cross) begin
            resp_rdata <= r_store ? '0 : rdata_ext;
            resp_fault <= 1'b0;
          end
        end
        ACC1: begin
          if (!r_store) buf_hi <= drdata;
          resp_rdata <= r_store ? '0 : rdata_ext;
          resp_fault <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/lsu_ctrl.md
# lsu_ctrl

Load/store unit sitting between the execute stage and `dmem`. It accepts one RV32I load or store per handshake and checks the address against the data-memory size. It drives `dmem`'s word-aligned address, shifted write data and per-byte write enables. For loads it extracts and sign/zero-extends the result from `drdata`. Accesses that cross a 32-bit word boundary are split into two sequential `dmem` accesses.

## Interface
Parameters (from package `parameters`):
- `MSB`, 31 — data/address MSB.
- `LSB`, 0 — data/address LSB.
- `DMEM_BYTES`, 128 — size of `dmem` in bytes.

Ports:
- `clk` in 1 — sole clock; all state updates on posedge.
- `rst` in 1 — synchronous, active-high reset.
- `req_valid` in 1 — request present.
- `req_ready` out 1 — unit can accept; high only in IDLE.
- `req_store` in 1 — 1 = store, 0 = load.
- `req_funct3` in 3 — RV32I funct3 (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `req_addr` in [MSB:LSB] — byte address (rs1+imm).
- `req_wdata` in [MSB:LSB] — store data, right-aligned.
- `resp_valid` out 1 — one-cycle completion pulse; no backpressure.
- `resp_rdata` out [MSB:LSB] — extended load result; 0 for stores and faults.
- `resp_fault` out 1 — illegal funct3 or out-of-range address.
- `daddr` out [MSB:LSB] — to `dmem`, word-aligned (low 2 bits 0).
- `dwdata` out [MSB:LSB] — to `dmem`, byte-lane-shifted store data.
- `we` out 4 — to `dmem`, per-byte write enables.
- `drdata` in [MSB:LSB] — from `dmem`, combinational read of `daddr`.

## Operation
- FSM states: IDLE, ACC0, ACC1, RESP.
- **IDLE:** `req_ready`=1. On `req_valid`, latch the request, compute size (1/2/4), offset `addr[1:0]`, `cross` = offset+size>4, and `fault`.
  - Go to RESP if `fault`, else go to ACC0.
- **fault** is asserted for:
  - illegal funct3: load 011/110/111; store with funct3 ≥ 011;
  - address out of range: `addr`+size−1 ≥ `DMEM_BYTES`.
  - A faulted store never asserts any `we` bit.
- **ACC0:** `daddr` = addr & ~3.
  - Store: `we` = mask<<offset, where mask is 0001/0011/1111 for byte/half/word, truncated to 4 bits. `dwdata` = wdata<<(8·offset).
  - Load: capture `drdata` into buf_lo.
  - Go to ACC1 if `cross`, else go to RESP.
- **ACC1:** `daddr` = (addr & ~3)+4.
  - Store: `we` = mask>>(4−offset). `dwdata` = wdata>>(8·(4−offset)).
  - Load: capture `drdata` into buf_hi.
  - Go to RESP.
- **RESP:** `resp_valid`=1. Go to IDLE.
  - Load result = ({buf_hi,buf_lo} >> 8·offset), then:
    - byte: sign-extend for LB, zero-extend for LBU;
    - half: sign-extend for LH, zero-extend for LHU;
    - word: unchanged.
- Outside ACC0/ACC1: `we`=0, `daddr`=0, `dwdata`=0.
- `resp_rdata`/`resp_fault` are registered and hold until the next RESP.
- Arithmetic is 32-bit unsigned. The range check uses a 33-bit sum, so an address near 0xFFFFFFFF faults rather than wrapping.

## Timing
- **Reset values:** state=IDLE, `req_ready`=1, `resp_valid`=0, `resp_rdata`=0, `resp_fault`=0, `we`=0, `daddr`=0, `dwdata`=0.
- **Latency from the accept edge (cycle 0):**
  - aligned or non-crossing access: `resp_valid` in cycle 2;
  - crossing access: `resp_valid` in cycle 3;
  - fault: `resp_valid` in cycle 1.
- Writes commit at the posedge ending ACC0/ACC1, through `dmem`'s `always_ff`.
- **Crossing store:** both halves always commit. There is no abort path except reset.
- **Back-to-back requests:** the next accept is possible in the cycle after RESP. Throughput is 1 request per 3 cycles (aligned).
- `req_*` is ignored while `req_ready`=0.
- **Reset mid-operation:** on the next edge, state returns to IDLE and `we` drops to 0. A crossing store interrupted after ACC0 leaves its first half written; this is an accepted outcome.

## Structure
- Add to package `parameters`:
  - `DMEM_BYTES`;
  - `typedef enum logic [1:0] {IDLE, ACC0, ACC1, RESP} lsu_state_t`;
  - funct3 constants `F3_B`/`F3_H`/`F3_W`/`F3_BU`/`F3_HU`.
- Sub-module `lsu_align` (combinational), containing store lane mask/shift generation and load shift plus sign/zero extension.
- `lsu_ctrl` holds the FSM, request registers, buf_lo/buf_hi and response registers.

## Test plan
- **SW aligned:** SW addr=0x10 wdata=0xDEADBEEF → ACC0 `we`=1111, `daddr`=0x10; LW 0x10 → `resp_rdata`=0xDEADBEEF in cycle 2, `resp_fault`=0.
- **Byte/half extension:** `dmem`[0x20..0x23]=80 FF 34 12:
  - LB 0x20 → 0xFFFFFF80;
  - LBU 0x20 → 0x00000080;
  - LH 0x22 → 0x00001234;
  - LH 0x20 → 0xFFFFFF80.
- **Crossing SW:** SW addr=0x13 wdata=0xAABBCCDD:
  - ACC0: `daddr`=0x10, `we`=1000, `dwdata`[31:24]=0xDD.
  - ACC1: `daddr`=0x14, `we`=0111, low 3 bytes = DD>>… i.e. CC,BB,AA in lanes 0..2.
  - LW 0x13 → 0xAABBCCDD at cycle 3.
- **Faults:**
  - LW 0x7E → `resp_fault`=1 in cycle 1, `we` never nonzero;
  - SB 0x80 → fault;
  - load funct3=011 → fault, `resp_rdata`=0.
- **Reset mid-crossing store:** assert `rst` during ACC1 → next cycle state IDLE, `we`=0, `req_ready`=1, `resp_valid` never asserts.
- **Back-to-back requests:** hold `req_valid` high with 3 aligned LWs → `req_ready` pattern 1,0,0,1,0,0,…, three `resp_valid` pulses in cycles 2, 5, 8.
